axi_lite_reg_bridge: RTL and testbench

- AXI-Lite slave endpoint that terminates the bus produced by a master-side `axi_lite_if` and converts each transaction into one access on a simple request/acknowledge register port.
- Sits between the SoC AXI-Lite fabric and peripheral register files (GPIO, UART, timer).
- Serialises reads and writes, checks alignment, and converts missing register acknowledges into SLVERR via a timeout.

---
 rtl/axi_lite_reg_bridge_if.sv | 33 +++
 rtl/axi_lite_reg_bridge.sv | 205 ++++++++++++++++++++
 tb/tb_axi_lite_reg_bridge.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_reg_bridge_if.sv
// AXI-Lite bus bundle between an SoC fabric master and the register bridge.
interface axi_lite_reg_bridge_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   AWADDR;
    logic            AWVALID;
    logic            AWREADY;
    logic [DW-1:0]   WDATA;
    logic [DW/8-1:0] WSTRB;
    logic            WVALID;
    logic            WREADY;
    logic [1:0]      BRESP;
    logic            BVALID;
    logic            BREADY;
    logic [AW-1:0]   ARADDR;
    logic            ARVALID;
    logic            ARREADY;
    logic [DW-1:0]   RDATA;
    logic [1:0]      RRESP;
    logic            RVALID;
    logic            RREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/axi_lite_reg_bridge.sv
// AXI-Lite slave that turns each transaction into a single req/ack register
// access. One capture buffer each for AW, W and AR; reads and writes are
// serialised through one FSM with a toggling priority bit; unaligned
// addresses and missing acks become SLVERR.
module axi_lite_reg_bridge #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            ACLK,
    input  logic            ARESETn,
    axi_lite_reg_bridge_if.slave s_axi,
    output logic            reg_req,
    output logic            reg_we,
    output logic [AW-1:0]   reg_addr,
    output logic [DW-1:0]   reg_wdata,
    output logic [DW/8-1:0] reg_wstrb,
    input  logic [DW-1:0]   reg_rdata,
    input  logic            reg_ack,
    input  logic            reg_err
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [7:0] TMO_LAST    = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_ACC, S_RD_ACC, S_WR_RESP, S_RD_RESP
    } state_t;

    state_t          r_state, w_state_nx;
    logic            r_live;
    logic            r_aw_held, r_w_held, r_ar_held;
    logic [AW-1:0]   r_aw_addr, r_ar_addr;
    logic [DW-1:0]   r_wdata;
    logic [DW/8-1:0] r_wstrb;
    logic            r_prio_rd;
    logic [7:0]      r_cnt;
    logic [1:0]      r_resp;
    logic [DW-1:0]   r_rdata;

    logic w_aw_hs, w_w_hs, w_ar_hs, w_b_hs, w_r_hs;
    logic w_wr_elig, w_rd_elig, w_grant_rd, w_grant_wr;
    logic w_wr_aligned, w_rd_aligned, w_in_acc, w_tmo;
    logic w_bvalid, w_rvalid;
    logic [1:0] w_bresp, w_rresp;

    // READYs stay low while reset is held and for the first edge after it,
    // so every output is 0 in reset.
    assign s_axi.AWREADY = r_live && !r_aw_held;
    assign s_axi.WREADY  = r_live && !r_w_held;
    assign s_axi.ARREADY = r_live && !r_ar_held;
    assign s_axi.BVALID  = w_bvalid;
    assign s_axi.BRESP   = w_bresp;
    assign s_axi.RVALID  = w_rvalid;
    assign s_axi.RRESP   = w_rresp;
    assign s_axi.RDATA   = r_rdata;

    assign w_aw_hs = s_axi.AWVALID && s_axi.AWREADY;
    assign w_w_hs  = s_axi.WVALID  && s_axi.WREADY;
    assign w_ar_hs = s_axi.ARVALID && s_axi.ARREADY;
    assign w_b_hs  = (r_state == S_WR_RESP) && s_axi.BREADY;
    assign w_r_hs  = (r_state == S_RD_RESP) && s_axi.RREADY;

    assign w_wr_elig    = r_aw_held && r_w_held;
    assign w_rd_elig    = r_ar_held;
    assign w_grant_rd   = (r_state == S_IDLE) && w_rd_elig && (!w_wr_elig || r_prio_rd);
    assign w_grant_wr   = (r_state == S_IDLE) && w_wr_elig && !w_grant_rd;
    assign w_wr_aligned = (r_aw_addr[1:0] == 2'b00);
    assign w_rd_aligned = (r_ar_addr[1:0] == 2'b00);

    assign w_in_acc = (r_state == S_WR_ACC) || (r_state == S_RD_ACC);
    assign w_tmo    = w_in_acc && !reg_ack && (r_cnt == TMO_LAST);

    // Marks the bridge live one edge after reset release.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) r_live <= 1'b0;
        else          r_live <= 1'b1;
    end

    // Capture buffers: filled on the channel handshake, freed on the response handshake.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_ar_held <= 1'b0;
            r_aw_addr <= '0;
            r_ar_addr <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_addr <= s_axi.AWADDR;
            end else if (w_b_hs) begin
                r_aw_held <= 1'b0;
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= s_axi.WDATA;
                r_wstrb  <= s_axi.WSTRB;
            end else if (w_b_hs) begin
                r_w_held <= 1'b0;
            end
            if (w_ar_hs) begin
                r_ar_held <= 1'b1;
                r_ar_addr <= s_axi.ARADDR;
            end else if (w_r_hs) begin
                r_ar_held <= 1'b0;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) r_state <= S_IDLE;
        else          r_state <= w_state_nx;
    end

    // FSM next state: arbitrate, issue or short-circuit unaligned, wait ack/timeout, wait response.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant_rd)      w_state_nx = w_rd_aligned ? S_RD_ACC : S_RD_RESP;
                else if (w_grant_wr) w_state_nx = w_wr_aligned ? S_WR_ACC : S_WR_RESP;
            end
            S_WR_ACC:  if (reg_ack || w_tmo) w_state_nx = S_WR_RESP;
            S_RD_ACC:  if (reg_ack || w_tmo) w_state_nx = S_RD_RESP;
            S_WR_RESP: if (s_axi.BREADY) w_state_nx = S_IDLE;
            S_RD_RESP: if (s_axi.RREADY) w_state_nx = S_IDLE;
            default:   w_state_nx = S_IDLE;
        endcase
    end

    // Priority bit, timeout counter and the response/read-data holding registers.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_prio_rd <= 1'b1;
            r_cnt     <= '0;
            r_resp    <= RESP_OKAY;
            r_rdata   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_rd_elig && w_wr_elig) r_prio_rd <= !r_prio_rd;
                    if (w_grant_rd) begin
                        r_resp <= w_rd_aligned ? RESP_OKAY : RESP_SLVERR;
                        if (!w_rd_aligned) r_rdata <= '0;
                    end else if (w_grant_wr) begin
                        r_resp <= w_wr_aligned ? RESP_OKAY : RESP_SLVERR;
                    end
                end
                S_WR_ACC, S_RD_ACC: begin
                    if (reg_ack) begin
                        r_resp <= reg_err ? RESP_SLVERR : RESP_OKAY;
                        if (r_state == S_RD_ACC) r_rdata <= reg_err ? '0 : reg_rdata;
                    end else if (w_tmo) begin
                        r_resp <= RESP_SLVERR;
                        if (r_state == S_RD_ACC) r_rdata <= '0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state; register fields come straight from the
    // capture buffers, which cannot change while the access is in flight.
    always_comb begin
        reg_req   = 1'b0;
        reg_we    = 1'b0;
        reg_addr  = '0;
        reg_wdata = '0;
        reg_wstrb = '0;
        w_bvalid  = 1'b0;
        w_bresp   = 2'b00;
        w_rvalid  = 1'b0;
        w_rresp   = 2'b00;
        case (r_state)
            S_WR_ACC: begin
                reg_req   = 1'b1;
                reg_we    = 1'b1;
                reg_addr  = r_aw_addr;
                reg_wdata = r_wdata;
                reg_wstrb = r_wstrb;
            end
            S_RD_ACC: begin
                reg_req  = 1'b1;
                reg_addr = r_ar_addr;
            end
            S_WR_RESP: begin
                w_bvalid = 1'b1;
                w_bresp  = r_resp;
            end
            S_RD_RESP: begin
                w_rvalid = 1'b1;
                w_rresp  = r_resp;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_axi_lite_reg_bridge.sv
// Directed bench for axi_lite_reg_bridge with queue-based scoreboard.
module tb_axi_lite_reg_bridge;
    localparam int AW = 32;
    localparam int DW = 32;

    logic ACLK = 1'b0;
    logic ARESETn = 1'b0;
    always #5 ACLK = ~ACLK;

    axi_lite_reg_bridge_if #(.AW(AW), .DW(DW)) bus();

    logic        reg_req, reg_we, reg_ack, reg_err;
    logic [31:0] reg_addr, reg_wdata, reg_rdata;
    logic [3:0]  reg_wstrb;

    axi_lite_reg_bridge #(.AW(AW), .DW(DW), .TIMEOUT(16)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .s_axi(bus.slave),
        .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb), .reg_rdata(reg_rdata),
        .reg_ack(reg_ack), .reg_err(reg_err)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [1:0]  q_b[$];     // expected BRESP
    logic [33:0] q_r[$];     // expected {RRESP, RDATA}
    logic [68:0] q_reg[$];   // expected {we, addr, wdata (writes only), wstrb}

    int          ack_delay = 0;
    bit          ack_en = 1'b1;
    logic [31:0] rd_val = '0;
    bit          stray_ack = 1'b0;

    int n_acc = 0;
    int last_len = 0;
    int n_rv = 0;

    task automatic chk(input string nm, input logic [68:0] act, input logic [68:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic flag_fail(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: event not as expected", nm);
    endtask

    // Register-side slave: acks the (ack_delay+1)-th reg_req cycle.
    initial begin
        int req_cyc;
        req_cyc = 0;
        reg_ack = 1'b0; reg_err = 1'b0; reg_rdata = '0;
        forever begin
            @(negedge ACLK);
            reg_ack = 1'b0;
            reg_err = 1'b0;
            if (!reg_req) req_cyc = 0;
            else begin
                if (ack_en && req_cyc == ack_delay) begin
                    reg_ack = 1'b1;
                    reg_rdata = rd_val;
                end
                req_cyc++;
            end
            if (stray_ack) begin
                reg_ack = 1'b1;
                stray_ack = 1'b0;
            end
        end
    end

    // Monitor: pops expectations on every B/R handshake and every new register access.
    initial begin
        bit prev;
        bit stable;
        int len;
        logic [68:0] cap;
        logic [68:0] cur;
        prev = 1'b0; stable = 1'b1; len = 0; cap = '0;
        forever begin
            @(negedge ACLK);
            if (bus.RVALID) n_rv++;
            if (bus.BVALID && bus.BREADY) begin
                if (q_b.size() == 0) flag_fail("b_unexpected");
                else chk("bresp", 69'(bus.BRESP), 69'(q_b.pop_front()));
            end
            if (bus.RVALID && bus.RREADY) begin
                if (q_r.size() == 0) flag_fail("r_unexpected");
                else chk("rresp_rdata", 69'({bus.RRESP, bus.RDATA}), 69'(q_r.pop_front()));
            end
            cur = {reg_we, reg_addr, (reg_we ? reg_wdata : 32'h0), reg_wstrb};
            if (reg_req && !prev) begin
                n_acc++;
                cap = cur; len = 1; stable = 1'b1;
                if (q_reg.size() == 0) flag_fail("reg_unexpected");
                else chk("reg_access", cur, q_reg.pop_front());
            end else if (reg_req) begin
                len++;
                if (cur !== cap) stable = 1'b0;
            end else if (prev) begin
                last_len = len;
                chk("reg_stable", 69'(stable), 69'(1));
            end
            prev = reg_req;
        end
    end

    task automatic send_aw(input logic [31:0] a);
        bit done;
        done = 1'b0;
        bus.AWADDR = a; bus.AWVALID = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge ACLK); done = bus.AWREADY;
            @(posedge ACLK); #1;
        end
        bus.AWVALID = 1'b0;
        if (!done) flag_fail("aw_handshake_timeout");
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        bit done;
        done = 1'b0;
        bus.WDATA = d; bus.WSTRB = s; bus.WVALID = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge ACLK); done = bus.WREADY;
            @(posedge ACLK); #1;
        end
        bus.WVALID = 1'b0;
        if (!done) flag_fail("w_handshake_timeout");
    endtask

    task automatic send_ar(input logic [31:0] a);
        bit done;
        done = 1'b0;
        bus.ARADDR = a; bus.ARVALID = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge ACLK); done = bus.ARREADY;
            @(posedge ACLK); #1;
        end
        bus.ARVALID = 1'b0;
        if (!done) flag_fail("ar_handshake_timeout");
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge ACLK);
            ok = (q_b.size() == 0) && (q_r.size() == 0) && (q_reg.size() == 0) &&
                 !reg_req && !bus.BVALID && !bus.RVALID;
        end
        @(posedge ACLK); #1;
        if (!ok) flag_fail("drain_timeout");
    endtask

    function automatic logic [68:0] all_outs();
        return 69'({bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID,
                    bus.BRESP, bus.RRESP, bus.RDATA, reg_req, reg_we, reg_wstrb});
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        int hold;
        bit seen;
        bus.AWADDR = '0; bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0;
        bus.ARADDR = '0; bus.ARVALID = 1'b0; bus.BREADY = 1'b1; bus.RREADY = 1'b1;

        // Reset state
        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_outputs", all_outs(), '0);
        chk("rst_reg_addr", 69'(reg_addr), '0);
        #1 ARESETn = 1'b1;
        @(posedge ACLK); #1;
        chk("ready_after_rst", 69'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 69'(3'b111));

        // Write then read
        ack_delay = 3;
        q_reg.push_back({1'b1, 32'h10, 32'hA5A5_0001, 4'hF});
        q_b.push_back(2'b00);
        fork
            send_aw(32'h10);
            send_w(32'hA5A5_0001, 4'hF);
        join
        wait_drain();
        chk("wr_req_len", 69'(last_len), 69'(4));
        ack_delay = 0;
        rd_val = 32'hA5A5_0001;
        q_reg.push_back({1'b0, 32'h10, 32'h0, 4'h0});
        q_r.push_back({2'b00, 32'hA5A5_0001});
        send_ar(32'h10);
        wait_drain();
        chk("rd_req_len", 69'(last_len), 69'(1));

        // W before AW
        snap = n_acc;
        q_reg.push_back({1'b1, 32'h20, 32'h0000_1234, 4'h3});
        q_b.push_back(2'b00);
        send_w(32'h0000_1234, 4'h3);
        repeat (4) @(posedge ACLK);
        #1;
        chk("w_first_no_req", 69'(n_acc), 69'(snap));
        chk("w_first_wready_low", 69'(bus.WREADY), 69'(0));
        send_aw(32'h20);
        wait_drain();
        chk("w_first_one_access", 69'(n_acc), 69'(snap + 1));

        // Unaligned read then write
        snap = n_acc;
        q_r.push_back({2'b10, 32'h0});
        send_ar(32'h13);
        wait_drain();
        q_b.push_back(2'b10);
        fork
            send_aw(32'h22);
            send_w(32'h55, 4'hF);
        join
        wait_drain();
        chk("unaligned_no_req", 69'(n_acc), 69'(snap));

        // Simultaneous eligibility: priority starts at read and toggles only on contention
        for (int r = 0; r < 3; r++) begin
            logic [31:0] base;
            base = 32'h100 + 32'(r * 16);
            rd_val = 32'h1000 + 32'(r);
            if (r != 1) begin
                q_reg.push_back({1'b0, base + 32'h4, 32'h0, 4'h0});
                q_reg.push_back({1'b1, base, 32'hB0 + 32'(r), 4'hF});
            end else begin
                q_reg.push_back({1'b1, base, 32'hB0 + 32'(r), 4'hF});
                q_reg.push_back({1'b0, base + 32'h4, 32'h0, 4'h0});
            end
            q_r.push_back({2'b00, 32'h1000 + 32'(r)});
            q_b.push_back(2'b00);
            fork
                send_aw(base);
                send_w(32'hB0 + 32'(r), 4'hF);
                send_ar(base + 32'h4);
            join
            wait_drain();
        end

        // Timeout, stray ack, then a normal access
        ack_en = 1'b0;
        q_reg.push_back({1'b0, 32'h40, 32'h0, 4'h0});
        q_r.push_back({2'b10, 32'h0});
        send_ar(32'h40);
        wait_drain();
        chk("tmo_req_len", 69'(last_len), 69'(16));
        ack_en = 1'b1;
        snap = n_rv;
        stray_ack = 1'b1;
        repeat (3) @(posedge ACLK);
        #1;
        chk("stray_ack_ignored", 69'({n_rv, bus.BVALID, reg_req}), 69'({snap, 2'b00}));
        rd_val = 32'hCAFE_F00D;
        q_reg.push_back({1'b0, 32'h44, 32'h0, 4'h0});
        q_r.push_back({2'b00, 32'hCAFE_F00D});
        send_ar(32'h44);
        wait_drain();

        // Backpressure on B
        bus.BREADY = 1'b0;
        ack_delay = 1;
        q_reg.push_back({1'b1, 32'h30, 32'hDEAD_BEEF, 4'hF});
        q_b.push_back(2'b00);
        fork
            send_aw(32'h30);
            send_w(32'hDEAD_BEEF, 4'hF);
        join
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge ACLK); seen = bus.BVALID;
        end
        if (!seen) flag_fail("bvalid_timeout");
        hold = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge ACLK);
            if (bus.BVALID && bus.BRESP == 2'b00 && !bus.AWREADY) hold++;
        end
        chk("bp_hold_cycles", 69'(hold), 69'(10));
        @(posedge ACLK); #1;
        bus.BREADY = 1'b1;
        wait_drain();

        // Reset in the middle of a read access
        ack_en = 1'b0;
        ack_delay = 0;
        q_reg.push_back({1'b0, 32'h50, 32'h0, 4'h0});
        send_ar(32'h50);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge ACLK); seen = reg_req;
        end
        if (!seen) flag_fail("rst_req_timeout");
        repeat (3) @(posedge ACLK);
        #3 ARESETn = 1'b0;
        #1;
        chk("rst_mid_req_drop", 69'(reg_req), 69'(0));
        chk("rst_mid_outputs", all_outs(), '0);
        snap = n_rv;
        @(posedge ACLK); @(posedge ACLK);
        #3 ARESETn = 1'b1;
        ack_en = 1'b1;
        repeat (20) @(posedge ACLK);
        #1;
        chk("rst_no_rvalid", 69'(n_rv), 69'(snap));
        rd_val = 32'h0BAD_F00D;
        q_reg.push_back({1'b0, 32'h54, 32'h0, 4'h0});
        q_r.push_back({2'b00, 32'h0BAD_F00D});
        send_ar(32'h54);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
